// File: rtl/result_display_driver_if.sv
// Request/status bundle between the calculator datapath and the display driver.
// The master drives a conversion request; the slave reports status and the scanned digit.
interface result_display_driver_if #(
    parameter int IN_WIDTH = 14
);
    logic                load;
    logic [IN_WIDTH-1:0] value;
    logic                negative;
    logic                blank_leading;
    logic                busy;
    logic                overflow;
    logic [3:0]          anode;
    logic [3:0]          digit;
    logic                dp;

    modport master (
        output load, value, negative, blank_leading,
        input  busy, overflow, anode, digit, dp
    );

    modport slave (
        input  load, value, negative, blank_leading,
        output busy, overflow, anode, digit, dp
    );
endinterface

// File: rtl/result_display_driver.sv
// Sequential double-dabble conversion of a signed result into four display digits,
// plus a free-running 4-digit multiplexed scan of the committed display register.
module result_display_driver #(
    parameter int         IN_WIDTH = 14,
    parameter logic [3:0] DP_MASK  = 4'b0000
) (
    input logic                    refresh_clock,
    input logic                    reset,
    result_display_driver_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam int         CW       = $clog2(IN_WIDTH + 1);

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [15:0]         bcd_q, bcd_d, bcd_adj;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic [3:0][3:0]     disp_q, disp_d, disp_new;
    logic [1:0]          scan_q, scan_d;
    logic [3:0]          anode_q, anode_d;
    logic [3:0]          digit_q, digit_d;
    logic                dp_q, dp_d;
    logic [31:0]         val_ext;
    logic                leading;

    assign val_ext = 32'(bus.value);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // The minus sign is skipped rather than ending the blanking run, so "-57" shows as "- 57".
    always_comb begin
        disp_new = bcd_q;
        leading  = bus.blank_leading;
        if (neg_q) disp_new[3] = 4'd10;
        for (int i = 3; i >= 1; i--) begin
            if (leading && disp_new[i] == 4'd0) disp_new[i] = 4'd15;
            else if (disp_new[i] != 4'd10)      leading     = 1'b0;
        end
        if (ovf_q) disp_new = {4{4'd10}};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        disp_d     = disp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    neg_d   = bus.negative && (bus.value != '0);
                    ovf_d   = (val_ext > 32'd9999) || (bus.negative && (val_ext > 32'd999));
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(IN_WIDTH - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                disp_d     = disp_new;
                overflow_d = ovf_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digit slot reads disp_q before a same-edge commit lands, so slots never tear.
    always_comb begin
        scan_d  = scan_q + 2'd1;
        anode_d = ~(4'b0001 << scan_q);
        digit_d = disp_q[scan_q];
        dp_d    = ~DP_MASK[scan_q];
    end

    always_ff @(posedge refresh_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
            scan_q     <= 2'd0;
            anode_q    <= 4'b1111;
            digit_q    <= 4'd15;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            disp_q     <= disp_d;
            scan_q     <= scan_d;
            anode_q    <= anode_d;
            digit_q    <= digit_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.anode    = anode_q;
    assign bus.digit    = digit_q;
    assign bus.dp       = dp_q;
endmodule

// File: tb/tb_result_display_driver.sv
// Randomized and directed bench for result_display_driver against a decimal-arithmetic model.
module tb_result_display_driver;
    localparam int         W    = 14;
    localparam logic [3:0] MASK = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] mask_v;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_display_driver_if #(.IN_WIDTH(W)) bus ();

    result_display_driver #(.IN_WIDTH(W), .DP_MASK(MASK)) dut (
        .refresh_clock(clk),
        .reset        (rst),
        .bus          (bus)
    );

    // Expected display as the user would read it: decimal digits, sign, blanking, dashes.
    function automatic void model(input int v, input bit neg, input bit bl,
                                  output logic [3:0][3:0] d, output bit ovf);
        int sig;
        ovf = (v > 9999) || (neg && v > 999);
        if (ovf) begin
            d = {4{4'd10}};
            return;
        end
        d[0] = 4'(v % 10);
        d[1] = 4'((v / 10) % 10);
        d[2] = 4'((v / 100) % 10);
        d[3] = 4'((v / 1000) % 10);
        sig = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
        if (bl) for (int i = sig; i < 4; i++) d[i] = 4'd15;
        if (neg && v != 0) d[3] = 4'd10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captures one full scan, indexed by the digit position the anode selects.
    task automatic observe_scan(output logic [3:0][3:0] dig, output logic [3:0] dpv, output int bad);
        int prev, s;
        prev = -1;
        bad  = 0;
        dig  = '1;
        dpv  = '1;
        for (int n = 0; n < 4; n++) begin
            tick();
            case (bus.anode)
                4'b1110: s = 0;
                4'b1101: s = 1;
                4'b1011: s = 2;
                4'b0111: s = 3;
                default: s = -1;
            endcase
            if (s < 0 || (prev >= 0 && s != (prev + 1) % 4)) bad++;
            else begin
                dig[s] = bus.digit;
                dpv[s] = bus.dp;
            end
            prev = s;
        end
    endtask

    // Issues one load and counts post-edge samples with busy high.
    task automatic run_load(input int v, input bit neg, input bit bl,
                            input int drop_at, input int rst_at, output int bcyc);
        bus.value         = W'(v);
        bus.negative      = neg;
        bus.blank_leading = bl;
        bus.load          = 1'b1;
        tick();
        bus.load = 1'b0;
        bcyc     = 0;
        while (bus.busy === 1'b1 && bcyc < 40) begin
            bcyc++;
            if (bcyc == drop_at) begin
                bus.value = W'(42);
                bus.load  = 1'b1;
            end else bus.load = 1'b0;
            rst = (bcyc == rst_at);
            tick();
        end
        bus.load = 1'b0;
        rst      = 1'b0;
        if (bcyc >= 40) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout value=%0d busy still %b after %0d cycles", v, bus.busy, bcyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL rst_anode got %b exp 1111", bus.anode); end
        checks++; if (bus.digit !== 4'd15)   begin errors++; $display("FAIL rst_digit got %0d exp 15", bus.digit); end
        checks++; if (bus.dp !== 1'b1)       begin errors++; $display("FAIL rst_dp got %b exp 1", bus.dp); end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            logic [3:0] ea;
            ea = ~(4'b0001 << n);
            tick();
            checks++;
            if (bus.anode !== ea || bus.digit !== 4'd0 || bus.dp !== ~mask_v[n] || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan%0d anode=%b digit=%0d dp=%b busy=%b exp anode=%b digit=0 dp=%b busy=0",
                         n, bus.anode, bus.digit, bus.dp, bus.busy, ea, ~mask_v[n]);
            end
        end
    endtask

    task automatic test_convert();
        int v, bc, bad;
        bit n, b, eo;
        logic [3:0][3:0] exp_d, dig;
        logic [3:0] dpv;
        for (int k = 0; k < 24; k++) begin
            if (k == 0) begin v = 1234; n = 0; b = 0; end
            else begin
                case ($urandom_range(0, 3))
                    0: v = $urandom_range(0, 9);
                    1: v = $urandom_range(0, 999);
                    2: v = $urandom_range(0, 9999);
                    default: v = $urandom_range(0, 16383);
                endcase
                n = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
            end
            run_load(v, n, b, -1, -1, bc);
            model(v, n, b, exp_d, eo);
            checks++; if (bc !== 15) begin errors++; $display("FAIL conv_busy v=%0d got %0d cycles exp 15", v, bc); end
            checks++; if (bus.overflow !== eo) begin errors++; $display("FAIL conv_ovf v=%0d n=%0d got %b exp %b", v, n, bus.overflow, eo); end
            observe_scan(dig, dpv, bad);
            checks++;
            if (dig !== exp_d || bad != 0) begin
                errors++;
                $display("FAIL conv_digits v=%0d n=%0d bl=%0d got %h bad=%0d exp %h", v, n, b, dig, bad, exp_d);
            end
            checks++; if (dpv !== ~mask_v) begin errors++; $display("FAIL conv_dp got %b exp %b", dpv, ~mask_v); end
        end
    endtask

    task automatic test_negative();
        int vt[4] = '{57, 0, 0, 57};
        bit nt[4] = '{1, 1, 0, 1};
        bit bt[4] = '{1, 1, 1, 0};
        int bc, bad;
        bit eo;
        logic [3:0][3:0] exp_d, dig;
        logic [3:0] dpv;
        for (int k = 0; k < 4; k++) begin
            run_load(vt[k], nt[k], bt[k], -1, -1, bc);
            model(vt[k], nt[k], bt[k], exp_d, eo);
            checks++; if (bus.overflow !== eo) begin errors++; $display("FAIL neg_ovf v=%0d got %b exp %b", vt[k], bus.overflow, eo); end
            observe_scan(dig, dpv, bad);
            checks++;
            if (dig !== exp_d || bad != 0 || bc !== 15) begin
                errors++;
                $display("FAIL neg_digits v=%0d n=%0d bl=%0d got %h bad=%0d busy=%0d exp %h busy=15",
                         vt[k], nt[k], bt[k], dig, bad, bc, exp_d);
            end
        end
    endtask

    task automatic test_overflow();
        int vt[4] = '{10000, 1000, 9999, 16383};
        bit nt[4] = '{0, 1, 0, 1};
        int bc, bad;
        bit eo;
        logic [3:0][3:0] exp_d, dig;
        logic [3:0] dpv;
        for (int k = 0; k < 4; k++) begin
            run_load(vt[k], nt[k], 1'b1, -1, -1, bc);
            model(vt[k], nt[k], 1'b1, exp_d, eo);
            checks++; if (bus.overflow !== eo) begin errors++; $display("FAIL ovf_flag v=%0d got %b exp %b", vt[k], bus.overflow, eo); end
            checks++; if (bc !== 15) begin errors++; $display("FAIL ovf_busy v=%0d got %0d exp 15", vt[k], bc); end
            observe_scan(dig, dpv, bad);
            checks++;
            if (dig !== exp_d || bad != 0) begin
                errors++;
                $display("FAIL ovf_digits v=%0d got %h bad=%0d exp %h", vt[k], dig, bad, exp_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, bad;
        bit eo;
        logic [3:0][3:0] exp_d, dig;
        logic [3:0] dpv;
        run_load(3141, 0, 0, 5, -1, bc);
        model(3141, 0, 0, exp_d, eo);
        checks++; if (bc !== 15) begin errors++; $display("FAIL drop_busy got %0d exp 15", bc); end
        observe_scan(dig, dpv, bad);
        checks++; if (dig !== exp_d || bad != 0) begin errors++; $display("FAIL drop_digits got %h bad=%0d exp %h", dig, bad, exp_d); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_requeued busy got %b exp 0", bus.busy); end
        run_load(808, 1, 1, 15, -1, bc);
        model(808, 1, 1, exp_d, eo);
        observe_scan(dig, dpv, bad);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL commit_load busy got %b exp 0", bus.busy); end
        checks++; if (dig !== exp_d || bad != 0) begin errors++; $display("FAIL commit_digits got %h bad=%0d exp %h", dig, bad, exp_d); end
    endtask

    task automatic test_reset_mid();
        int bc, bad;
        logic [3:0][3:0] dig;
        logic [3:0] dpv;
        logic [3:0][3:0] zero_d;
        zero_d = '0;
        run_load(10000, 0, 0, -1, -1, bc);
        run_load(8765, 0, 0, -1, 7, bc);
        checks++; if (bc !== 7) begin errors++; $display("FAIL rstmid_busy got %0d cycles exp 7", bc); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", bus.overflow); end
        observe_scan(dig, dpv, bad);
        checks++; if (dig !== zero_d || bad != 0) begin errors++; $display("FAIL rstmid_digits got %h bad=%0d exp 0000", dig, bad); end
        checks++; if (dpv !== ~mask_v) begin errors++; $display("FAIL rstmid_dp got %b exp %b", dpv, ~mask_v); end
        repeat (16) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_commit busy got %b exp 0", bus.busy); end
        observe_scan(dig, dpv, bad);
        checks++; if (dig !== zero_d || bad != 0) begin errors++; $display("FAIL rstmid_late got %h bad=%0d exp 0000", dig, bad); end
    endtask

    initial begin
        mask_v            = MASK;
        bus.load          = 1'b0;
        bus.value         = '0;
        bus.negative      = 1'b0;
        bus.blank_leading = 1'b0;
        test_reset();
        test_convert();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
